// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer: FSM state encoding, default
// parameter values and the player-index width helper.
package game_pkg;

  localparam int DEF_NUM_PLAYERS = 2;
  localparam int DEF_WIN_SCORE   = 8;
  localparam int DEF_SCORE_W     = 4;
  localparam int DEF_TIMEOUT_CYC = 50_000_000;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARM      = 3'd1,
    S_TURN     = 3'd2,
    S_REQ      = 3'd3,
    S_WAIT_CMP = 3'd4,
    S_HIT      = 3'd5,
    S_MISS     = 3'd6,
    S_OVER     = 3'd7
  } state_t;

  // Width of a player index: max(1, clog2(n)).
  function automatic int player_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Handshake bundle between the game sequencer and its environment
// (board generator, player button, comparator, score display).
//   master : the sequencer side (drives gen_req, cmp_req, hit, player,
//            scores, game_over, winner; receives gen_done, key, cmp_valid,
//            cmp_hit)
//   slave  : the environment side (mirror image)
interface game_sequencer_if #(
  parameter int NUM_PLAYERS = game_pkg::DEF_NUM_PLAYERS,
  parameter int SCORE_W     = game_pkg::DEF_SCORE_W
) ();

  localparam int PW = game_pkg::player_w(NUM_PLAYERS);

  logic                           gen_done;
  logic                           key;
  logic                           cmp_valid;
  logic                           cmp_hit;
  logic                           gen_req;
  logic                           cmp_req;
  logic                           hit;
  logic [PW-1:0]                  player;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores;
  logic                           game_over;
  logic [PW-1:0]                  winner;

  modport master (
    input  gen_done, key, cmp_valid, cmp_hit,
    output gen_req, cmp_req, hit, player, scores, game_over, winner
  );

  modport slave (
    output gen_done, key, cmp_valid, cmp_hit,
    input  gen_req, cmp_req, hit, player, scores, game_over, winner
  );

endinterface

// File: rtl/turn_timer.sv
// Turn timeout down-counter.
//   CLK, RST : clock, asynchronous active-high reset
//   clr      : force the count to zero (highest priority)
//   load     : load TIMEOUT_CYC-1
//   en       : count down by one, stopping at zero
//   expire   : count has reached zero; tied low when TIMEOUT_CYC == 0
// Loaded while the turn is not running, so the first turn cycle sees
// TIMEOUT_CYC-1 and expire rises on the TIMEOUT_CYC-th turn cycle.
module turn_timer
  import game_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] LOAD_VAL = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  logic [TW-1:0] count_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                          count_q <= '0;
    else if (clr)                     count_q <= '0;
    else if (load)                    count_q <= LOAD_VAL;
    else if (en && count_q != '0)     count_q <= count_q - TW'(1);
  end

  assign expire = (TIMEOUT_CYC != 0) && (count_q == '0);

endmodule

// File: rtl/game_sequencer.sv
// Turn-based game sequencer. Requests a board, then rotates turns between
// players: each key press in a turn issues a comparison request; a hit
// scores for the current player (who keeps the turn), a miss or a turn
// timeout passes the turn on. The first player to reach WIN_SCORE wins.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : game_sequencer_if.master -- gen_done/key/cmp_valid/cmp_hit in,
//              gen_req/cmp_req/hit/player/scores/game_over/winner out
// All outputs are registers or decodes of the state register.
module game_sequencer
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS = DEF_NUM_PLAYERS,
  parameter int WIN_SCORE   = DEF_WIN_SCORE,
  parameter int SCORE_W     = DEF_SCORE_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             CLK,
  input  logic             RST,
  game_sequencer_if.master bus
);

  localparam int PW = player_w(NUM_PLAYERS);

  state_t                         state_q, state_d;
  logic [PW-1:0]                  player_q;
  logic [PW-1:0]                  winner_q;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores_flat;
  logic [SCORE_W-1:0]             cur_score;
  logic [SCORE_W:0]               next_score;
  logic                           cur_win;
  logic                           start;
  logic                           expire;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Score of the current player and whether one more hit wins.
  always_comb begin
    cur_score = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (player_q == PW'(i)) cur_score = scores_flat[i*SCORE_W +: SCORE_W];
    end
    next_score = {1'b0, cur_score} + (SCORE_W+1)'(1);
    cur_win    = (next_score == (SCORE_W+1)'(WIN_SCORE));
  end

  // NOTE: every signal written here gets a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      S_IDLE:     if (bus.gen_done) state_d = S_ARM;
      S_ARM: begin
        if (bus.key) begin
          state_d = S_TURN;
          start   = 1'b1;
        end
      end
      // A key press wins over a coincident timeout.
      S_TURN: begin
        if (bus.key)     state_d = S_REQ;
        else if (expire) state_d = S_MISS;
      end
      S_REQ:      state_d = S_WAIT_CMP;
      S_WAIT_CMP: begin
        if (bus.cmp_valid) state_d = bus.cmp_hit ? S_HIT : S_MISS;
      end
      S_HIT:      state_d = cur_win ? S_OVER : S_TURN;
      S_MISS:     state_d = S_TURN;
      S_OVER:     if (bus.key) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Timer reloads whenever the turn is not running, so every entry to TURN
  // starts a fresh timeout.
  turn_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_turn_timer (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (state_q == S_IDLE),
    .load   (state_q != S_TURN),
    .en     (state_q == S_TURN),
    .expire (expire)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      player_q <= '0;
    end else if (start) begin
      player_q <= '0;
    end else if (state_q == S_MISS) begin
      player_q <= (player_q == PW'(NUM_PLAYERS - 1)) ? '0 : player_q + PW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                            winner_q <= '0;
    else if (state_q == S_HIT && cur_win) winner_q <= player_q;
  end

  // Per-player score counters; the WIN_SCORE guard keeps them from wrapping.
  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_score
    logic [SCORE_W-1:0] score_q;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        score_q <= '0;
      end else if (start) begin
        score_q <= '0;
      end else if (state_q == S_HIT && player_q == PW'(i) &&
                   score_q != SCORE_W'(WIN_SCORE)) begin
        score_q <= score_q + SCORE_W'(1);
      end
    end

    assign scores_flat[i*SCORE_W +: SCORE_W] = score_q;
  end

  assign bus.gen_req   = (state_q == S_IDLE);
  assign bus.cmp_req   = (state_q == S_REQ);
  assign bus.hit       = (state_q == S_HIT);
  assign bus.game_over = (state_q == S_OVER);
  assign bus.player    = player_q;
  assign bus.winner    = winner_q;
  assign bus.scores    = scores_flat;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer. Three instances cover the configurations
// of interest:
//   u_dut0 : 3 players, win at 2, no timeout   (game, wrap, ignore, mid reset)
//   u_dut1 : 2 players, win at 8, timeout 10   (turn timeout)
//   u_dut2 : 2 players, win at 15, 4-bit score (saturation)
module tb_game_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;
  int   tests  = 0;
  int   failed = 0;

  game_sequencer_if #(.NUM_PLAYERS(3), .SCORE_W(4)) if0 ();
  game_sequencer_if #(.NUM_PLAYERS(2), .SCORE_W(4)) if1 ();
  game_sequencer_if #(.NUM_PLAYERS(2), .SCORE_W(4)) if2 ();

  game_sequencer #(.NUM_PLAYERS(3), .WIN_SCORE(2), .SCORE_W(4), .TIMEOUT_CYC(0))
    u_dut0 (.CLK(clk), .RST(rst0), .bus(if0));
  game_sequencer #(.NUM_PLAYERS(2), .WIN_SCORE(8), .SCORE_W(4), .TIMEOUT_CYC(10))
    u_dut1 (.CLK(clk), .RST(rst1), .bus(if1));
  game_sequencer #(.NUM_PLAYERS(2), .WIN_SCORE(15), .SCORE_W(4), .TIMEOUT_CYC(0))
    u_dut2 (.CLK(clk), .RST(rst2), .bus(if2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete turn on u_dut0: key, request, comparator answer, return.
  task automatic turn0(input string tag, input logic is_hit, input logic [1:0] exp_player,
                       input logic [11:0] exp_scores, input logic exp_over);
    if0.key = 1'b1; step(); if0.key = 1'b0;
    tests++; if (if0.cmp_req !== 1'b1) begin failed++; $display("FAIL %s cmp_req_after_key: got %b expected 1", tag, if0.cmp_req); end
    step();
    tests++; if (if0.cmp_req !== 1'b0) begin failed++; $display("FAIL %s cmp_req_one_cycle: got %b expected 0", tag, if0.cmp_req); end
    if0.cmp_valid = 1'b1; if0.cmp_hit = is_hit; step(); if0.cmp_valid = 1'b0; if0.cmp_hit = 1'b0;
    tests++; if (if0.hit !== is_hit) begin failed++; $display("FAIL %s hit_pulse: got %b expected %b", tag, if0.hit, is_hit); end
    step();
    tests++;
    if ({if0.hit, if0.player, if0.scores, if0.game_over} !== {1'b0, exp_player, exp_scores, exp_over}) begin
      failed++;
      $display("FAIL %s after_turn: got hit=%b player=%0d scores=%h over=%b expected hit=0 player=%0d scores=%h over=%b",
               tag, if0.hit, if0.player, if0.scores, if0.game_over, exp_player, exp_scores, exp_over);
    end
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    #2;
    tests++; if (if0.gen_req !== 1'b1) begin failed++; $display("FAIL reset_gen_req: got %b expected 1", if0.gen_req); end
    tests++;
    if ({if0.cmp_req, if0.hit, if0.game_over, if0.player, if0.winner, if0.scores} !== '0) begin
      failed++;
      $display("FAIL reset_outputs: got cmp_req=%b hit=%b over=%b player=%0d winner=%0d scores=%h expected all 0",
               if0.cmp_req, if0.hit, if0.game_over, if0.player, if0.winner, if0.scores);
    end
    tests++; if ({if1.gen_req, if2.gen_req} !== 2'b11) begin failed++; $display("FAIL reset_gen_req_others: got %b expected 11", {if1.gen_req, if2.gen_req}); end
    step(); step();
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    step(); step();
    tests++; if (if0.gen_req !== 1'b1) begin failed++; $display("FAIL idle_hold: got gen_req=%b expected 1", if0.gen_req); end
  endtask

  task automatic test_win();
    if0.gen_done = 1'b1; step(); if0.gen_done = 1'b0;
    tests++; if (if0.gen_req !== 1'b0) begin failed++; $display("FAIL arm_gen_req: got %b expected 0", if0.gen_req); end
    if0.key = 1'b1; step(); if0.key = 1'b0;
    tests++; if ({if0.player, if0.scores, if0.game_over} !== 15'd0) begin failed++; $display("FAIL start_turn: got player=%0d scores=%h over=%b expected 0", if0.player, if0.scores, if0.game_over); end
    turn0("win_hit1", 1'b1, 2'd0, 12'h001, 1'b0);
    turn0("win_hit2", 1'b1, 2'd0, 12'h002, 1'b1);
    tests++; if (if0.winner !== 2'd0) begin failed++; $display("FAIL winner: got %0d expected 0", if0.winner); end
  endtask

  task automatic test_ignore();
    // OVER holds against a stray comparator result.
    if0.cmp_valid = 1'b1; if0.cmp_hit = 1'b1; step(); if0.cmp_valid = 1'b0; if0.cmp_hit = 1'b0;
    step();
    tests++; if ({if0.game_over, if0.hit, if0.scores} !== {1'b1, 1'b0, 12'h002}) begin failed++; $display("FAIL over_hold: got over=%b hit=%b scores=%h expected over=1 hit=0 scores=002", if0.game_over, if0.hit, if0.scores); end
    if0.key = 1'b1; step(); if0.key = 1'b0;
    tests++; if ({if0.gen_req, if0.game_over} !== 2'b10) begin failed++; $display("FAIL over_key_idle: got gen_req=%b over=%b expected gen_req=1 over=0", if0.gen_req, if0.game_over); end
    // IDLE ignores key and comparator.
    if0.key = 1'b1; if0.cmp_valid = 1'b1; if0.cmp_hit = 1'b1; step();
    if0.key = 1'b0; if0.cmp_valid = 1'b0; if0.cmp_hit = 1'b0;
    tests++; if ({if0.gen_req, if0.hit} !== 2'b10) begin failed++; $display("FAIL idle_ignore: got gen_req=%b hit=%b expected gen_req=1 hit=0", if0.gen_req, if0.hit); end
    // New game clears scores.
    if0.gen_done = 1'b1; step(); if0.gen_done = 1'b0;
    if0.key = 1'b1; step(); if0.key = 1'b0;
    tests++; if ({if0.player, if0.scores} !== 14'd0) begin failed++; $display("FAIL restart_clear: got player=%0d scores=%h expected 0", if0.player, if0.scores); end
    // REQ ignores key and comparator; the later miss must still be seen.
    if0.key = 1'b1; step(); if0.key = 1'b0;
    tests++; if (if0.cmp_req !== 1'b1) begin failed++; $display("FAIL ignore_req_entry: got cmp_req=%b expected 1", if0.cmp_req); end
    if0.key = 1'b1; if0.cmp_valid = 1'b1; if0.cmp_hit = 1'b1; step();
    if0.key = 1'b0; if0.cmp_valid = 1'b0; if0.cmp_hit = 1'b0;
    tests++; if ({if0.cmp_req, if0.hit} !== 2'b00) begin failed++; $display("FAIL req_ignore: got cmp_req=%b hit=%b expected 0 0", if0.cmp_req, if0.hit); end
    step();
    tests++; if ({if0.cmp_req, if0.hit, if0.gen_req} !== 3'b000) begin failed++; $display("FAIL wait_idle: got cmp_req=%b hit=%b gen_req=%b expected 000", if0.cmp_req, if0.hit, if0.gen_req); end
    if0.cmp_valid = 1'b1; if0.cmp_hit = 1'b0; step(); if0.cmp_valid = 1'b0;
    step();
    tests++; if ({if0.player, if0.scores} !== {2'd1, 12'h000}) begin failed++; $display("FAIL wait_miss: got player=%0d scores=%h expected player=1 scores=000", if0.player, if0.scores); end
  endtask

  task automatic test_wrap();
    turn0("p1_miss", 1'b0, 2'd2, 12'h000, 1'b0);
    turn0("p2_hit",  1'b1, 2'd2, 12'h100, 1'b0);
    turn0("p2_miss", 1'b0, 2'd0, 12'h100, 1'b0);
  endtask

  task automatic test_reset_mid();
    if0.key = 1'b1; step(); if0.key = 1'b0;
    step();
    rst0 = 1'b1;
    #2;
    tests++; if ({if0.gen_req, if0.player, if0.scores, if0.cmp_req} !== {1'b1, 2'd0, 12'h000, 1'b0}) begin failed++; $display("FAIL mid_reset_async: got gen_req=%b player=%0d scores=%h cmp_req=%b expected 1 0 000 0", if0.gen_req, if0.player, if0.scores, if0.cmp_req); end
    step(); rst0 = 1'b0; step();
    if0.cmp_valid = 1'b1; if0.cmp_hit = 1'b1; step(); if0.cmp_valid = 1'b0; if0.cmp_hit = 1'b0;
    tests++; if ({if0.hit, if0.gen_req, if0.scores} !== {1'b0, 1'b1, 12'h000}) begin failed++; $display("FAIL late_cmp_valid: got hit=%b gen_req=%b scores=%h expected hit=0 gen_req=1 scores=000", if0.hit, if0.gen_req, if0.scores); end
    step();
    tests++; if ({if0.hit, if0.gen_req} !== 2'b01) begin failed++; $display("FAIL late_cmp_idle: got hit=%b gen_req=%b expected 0 1", if0.hit, if0.gen_req); end
  endtask

  task automatic test_timeout();
    if1.gen_done = 1'b1; step(); if1.gen_done = 1'b0;
    if1.key = 1'b1; step(); if1.key = 1'b0;
    // Ten TURN cycles, then MISS; the player advances when MISS exits.
    for (int i = 1; i <= 10; i++) step();
    tests++; if ({if1.player, if1.cmp_req} !== 2'b00) begin failed++; $display("FAIL timeout_in_miss: got player=%0d cmp_req=%b expected player=0 cmp_req=0", if1.player, if1.cmp_req); end
    step();
    tests++; if (if1.player !== 1'd1) begin failed++; $display("FAIL timeout_advance: got player=%0d expected 1", if1.player); end
    // Key on the tenth TURN cycle beats the coincident expiry.
    for (int i = 1; i <= 9; i++) step();
    if1.key = 1'b1; step(); if1.key = 1'b0;
    tests++; if ({if1.cmp_req, if1.player} !== 2'b11) begin failed++; $display("FAIL timeout_key_priority: got cmp_req=%b player=%0d expected cmp_req=1 player=1", if1.cmp_req, if1.player); end
    step();
    if1.cmp_valid = 1'b1; if1.cmp_hit = 1'b1; step(); if1.cmp_valid = 1'b0; if1.cmp_hit = 1'b0;
    tests++; if (if1.hit !== 1'b1) begin failed++; $display("FAIL timeout_then_hit: got hit=%b expected 1", if1.hit); end
    step();
    tests++; if ({if1.player, if1.scores} !== {1'd1, 8'h10}) begin failed++; $display("FAIL timeout_score: got player=%0d scores=%h expected player=1 scores=10", if1.player, if1.scores); end
  endtask

  task automatic test_saturate();
    if2.gen_done = 1'b1; step(); if2.gen_done = 1'b0;
    if2.key = 1'b1; step(); if2.key = 1'b0;
    for (int h = 1; h <= 15; h++) begin
      if2.key = 1'b1; step(); if2.key = 1'b0;
      step();
      if2.cmp_valid = 1'b1; if2.cmp_hit = 1'b1; step(); if2.cmp_valid = 1'b0; if2.cmp_hit = 1'b0;
      tests++; if (if2.hit !== 1'b1) begin failed++; $display("FAIL sat_hit_%0d: got hit=%b expected 1", h, if2.hit); end
      step();
      tests++;
      if ({if2.scores, if2.game_over} !== {8'(h), (h == 15)}) begin
        failed++;
        $display("FAIL sat_score_%0d: got scores=%h over=%b expected scores=%h over=%b", h, if2.scores, if2.game_over, 8'(h), (h == 15));
      end
    end
    if2.cmp_valid = 1'b1; if2.cmp_hit = 1'b1; step(); if2.cmp_valid = 1'b0; if2.cmp_hit = 1'b0;
    step();
    tests++; if ({if2.scores, if2.game_over, if2.winner} !== {8'h0f, 1'b1, 1'b0}) begin failed++; $display("FAIL sat_no_wrap: got scores=%h over=%b winner=%0d expected scores=0f over=1 winner=0", if2.scores, if2.game_over, if2.winner); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    {if0.gen_done, if0.key, if0.cmp_valid, if0.cmp_hit} = '0;
    {if1.gen_done, if1.key, if1.cmp_valid, if1.cmp_hit} = '0;
    {if2.gen_done, if2.key, if2.cmp_valid, if2.cmp_hit} = '0;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    test_reset();
    test_win();
    test_ignore();
    test_wrap();
    test_reset_mid();
    test_timeout();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2: number of players in rotation, 2..8.
REQ-002 SHALL have parameter WIN_SCORE, default 8: number of hits a player needs to win, 1..2^SCORE_W-1.
REQ-003 SHALL have parameter SCORE_W, default 4: width of each per-player score counter.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 50_000_000: cycles allowed for a turn key press; 0 disables the timeout.
REQ-005 SHALL have port CLK  input  1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port RST  input  1: asynchronous, active-high reset.
REQ-007 SHALL have port gen_done  input  1: random board generation complete (level).
REQ-008 SHALL have port key  input  1: one-cycle pulse from a debounced player button.
REQ-009 SHALL have port cmp_valid  input  1: one-cycle pulse; comparator result is ready.
REQ-010 SHALL have port cmp_hit  input  1: comparator result, sampled only while cmp_valid=1.
REQ-011 SHALL have port gen_req  output  1: request for a new board; high in IDLE.
REQ-012 SHALL have port cmp_req  output  1: one-cycle comparison request pulse.
REQ-013 SHALL have port hit  output  1: one-cycle pulse on each accepted hit.
REQ-014 SHALL have port player  output  PW: index of the current player, where PW = max(1, clog2(NUM_PLAYERS)).
REQ-015 SHALL have port scores  output  NUM_PLAYERS*SCORE_W: packed scores, with player i at bits [i*SCORE_W +: SCORE_W].
REQ-016 SHALL have port game_over  output  1: level, high while the FSM is in OVER.
REQ-017 SHALL have port winner  output  PW: index of the winning player, valid while game_over=1.

Function
REQ-018 SHALL implement FSM states IDLE, ARM, TURN, REQ, WAIT_CMP, HIT, MISS, OVER.
REQ-019 SHALL move from IDLE to ARM on the first cycle gen_done=1, and otherwise hold IDLE.
REQ-020 SHALL move from ARM to TURN on key, clear all scores, set player to 0, and clear the timeout counter.
REQ-021 SHALL, in TURN, move to REQ on key; if no key arrives, it SHALL move to MISS when the timeout counter reaches TIMEOUT_CYC-1 (when TIMEOUT_CYC≠0).
REQ-022 SHALL give key priority when key and timeout expiry coincide.
REQ-023 SHALL assert cmp_req for exactly the one cycle spent in REQ, then go to WAIT_CMP.
REQ-024 SHALL, in WAIT_CMP, go to HIT on cmp_valid&cmp_hit, go to MISS on cmp_valid&!cmp_hit, and otherwise wait indefinitely.
REQ-025 SHALL ignore key outside ARM, TURN and OVER.
REQ-026 SHALL ignore cmp_valid outside WAIT_CMP.
REQ-027 SHALL, in HIT, pulse hit for one cycle and increment the current player's score.
REQ-028 SHALL, in HIT, go to OVER with winner=player if the new score equals WIN_SCORE, and otherwise return to TURN with the same player.
REQ-029 SHALL, in MISS, advance player to (player+1) mod NUM_PLAYERS, wrapping NUM_PLAYERS-1 to 0, and return to TURN.
REQ-030 SHALL restart the timeout counter on every entry to TURN.
REQ-031 SHALL hold scores, winner and game_over in OVER until key, which SHALL go to IDLE.
REQ-032 SHALL never wrap a score counter; increments stop at WIN_SCORE.
REQ-033 SHALL have TURN→cmp_req latency of exactly 1 cycle after the key cycle.
REQ-034 SHALL drive all outputs from registers or as decodes of the state register only, with no combinational path from inputs to outputs.

Reset
REQ-035 SHALL, on RST, immediately force state=IDLE, player=0, scores=0, winner=0, the timeout counter to 0, and cmp_req=hit=game_over=0.
REQ-036 SHALL drive gen_req=1 while in IDLE, including directly after reset.
REQ-037 SHALL abandon any game or pending comparison when RST is asserted mid-operation, and SHALL treat a late cmp_valid as ignored.
REQ-038 SHALL leave reset on the first rising CLK edge after RST deasserts.

Structure
REQ-039 SHALL place the state enumeration (8 codes, 3 bits) and the default parameter constants in a shared package, game_pkg.
REQ-040 SHALL contain one sub-module, turn_timer: a loadable down-counter with clear/enable/expire, parameterised by TIMEOUT_CYC.
REQ-041 SHALL keep the score counters inline as a generate array indexed by player.

Verification
REQ-042 SHALL cover: NUM_PLAYERS=3, WIN_SCORE=2, TIMEOUT_CYC=0; gen_done, key, then key+hit ×2 → cmp_req 1 cycle after each key, hit pulses, game_over=1, winner=0, scores[3:0]=2.
REQ-043 SHALL cover: player 2 misses → player wraps to 0, and player 2's score is unchanged.
REQ-044 SHALL cover: TIMEOUT_CYC=10, no key in TURN → MISS after 10 cycles and player advances; key on cycle 10 → REQ taken, no MISS.
REQ-045 SHALL cover: RST asserted in WAIT_CMP, then cmp_valid after release → state IDLE, gen_req=1, scores=0, no hit pulse.
REQ-046 SHALL cover: key and cmp_valid in IDLE or REQ → no state change; key in OVER → IDLE with gen_req=1.
REQ-047 SHALL cover: NUM_PLAYERS=2, WIN_SCORE=15, SCORE_W=4, 15 hits → score saturates at 15, game_over=1, no wrap.
